// File: rtl/dcache_line_xfer_ctrl.sv
// dcache_line_xfer_ctrl
// Moves whole cache lines between the data cache and BRAM port B.
// A miss request optionally writes back the dirty victim line, then refills
// the requested line. Only one transaction is in flight at a time. Port A of
// the BRAM stays with the core and is not touched here.
//
// state | meaning
// IDLE  | waiting for a miss request; req_ready high
// WB    | one victim word written to BRAM per cycle
// FILL  | one BRAM read issued per cycle for the refill line
// DRAIN | no BRAM access; the last refill word lands in the cache
// DONE  | done pulse for one cycle, then back to IDLE

module dcache_line_xfer_ctrl #(
    parameter int ADDR_WIDTH     = 12,
    parameter int NUM_COL        = 4,
    parameter int COL_WIDTH      = 8,
    parameter int WORDS_PER_LINE = 4,
    localparam int DATA_WIDTH    = NUM_COL * COL_WIDTH,
    localparam int IDXW          = $clog2(WORDS_PER_LINE),
    localparam int LINEW         = ADDR_WIDTH - IDXW
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wb,
    input  logic [LINEW-1:0]      req_wb_line,
    input  logic [LINEW-1:0]      req_fill_line,
    output logic [IDXW-1:0]       wb_rd_idx,
    input  logic [DATA_WIDTH-1:0] wb_rd_data,
    output logic                  fill_we,
    output logic [IDXW-1:0]       fill_idx,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  done,
    output logic                  mem_en,
    output logic [NUM_COL-1:0]    mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB    = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [IDXW-1:0]  r_cnt;
    logic [LINEW-1:0] r_wb_line;
    logic [LINEW-1:0] r_fill_line;
    logic             r_fill_vld;
    logic [IDXW-1:0]  r_fill_idx;

    logic [IDXW-1:0]  w_cnt_inc;
    logic             w_cnt_last;

    // The word counter wraps by itself; the phase end is the all-ones index.
    assign w_cnt_inc  = r_cnt + IDXW'(1);
    assign w_cnt_last = (r_cnt == {IDXW{1'b1}});

    // Main sequencer: capture the request, walk the line once per phase.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wb_line   <= '0;
            r_fill_line <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_wb_line   <= req_wb_line;
                        r_fill_line <= req_fill_line;
                        r_cnt       <= '0;
                        r_state     <= req_wb ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_last) begin
                        r_state <= S_FILL;
                    end
                end
                S_FILL: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // BRAM read data arrives one cycle after the read, so remember which
    // index was issued and write it into the cache on the following cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_fill_vld <= 1'b0;
            r_fill_idx <= '0;
        end else begin
            r_fill_vld <= (r_state == S_FILL);
            r_fill_idx <= (r_state == S_FILL) ? r_cnt : '0;
        end
    end

    // Output decode; anything without a role in the current state stays 0.
    always_comb begin
        req_ready = (r_state == S_IDLE);
        done      = (r_state == S_DONE);
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_din   = '0;
        wb_rd_idx = '0;
        case (r_state)
            S_WB: begin
                mem_en    = 1'b1;
                mem_we    = {NUM_COL{1'b1}};
                mem_addr  = {r_wb_line, r_cnt};
                mem_din   = wb_rd_data;
                wb_rd_idx = r_cnt;
            end
            S_FILL: begin
                mem_en   = 1'b1;
                mem_addr = {r_fill_line, r_cnt};
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
        fill_we   = r_fill_vld;
        fill_idx  = r_fill_vld ? r_fill_idx : '0;
        fill_data = r_fill_vld ? mem_dout : '0;
    end

endmodule

// File: tb/tb_dcache_line_xfer_ctrl.sv
// Bench for dcache_line_xfer_ctrl: directed scenarios with literal expectations,
// an 8-word-line instance, then random traffic against a per-cycle timeline model.
module tb_dcache_line_xfer_ctrl;

    localparam int AW  = 12;
    localparam int NC  = 4;
    localparam int CW  = 8;
    localparam int DW  = 32;
    localparam int W   = 4;
    localparam int IW  = 2;
    localparam int LW  = AW - IW;
    localparam int W8  = 8;
    localparam int IW8 = 3;
    localparam int LW8 = AW - IW8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- W=4 instance ----------------
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wb = 1'b0;
    logic [LW-1:0] req_wb_line = '0;
    logic [LW-1:0] req_fill_line = '0;
    logic [IW-1:0] wb_rd_idx;
    logic [DW-1:0] wb_rd_data;
    logic          fill_we;
    logic [IW-1:0] fill_idx;
    logic [DW-1:0] fill_data;
    logic          done;
    logic          mem_en;
    logic [NC-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] cache [0:W-1];
    logic [DW-1:0] bram [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    assign wb_rd_data = cache[wb_rd_idx];

    dcache_line_xfer_ctrl #(.ADDR_WIDTH(AW), .NUM_COL(NC), .COL_WIDTH(CW), .WORDS_PER_LINE(W)) u_dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready), .req_wb(req_wb),
        .req_wb_line(req_wb_line), .req_fill_line(req_fill_line), .wb_rd_idx(wb_rd_idx),
        .wb_rd_data(wb_rd_data), .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
        .done(done), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout));

    // ---------------- W=8 instance ----------------
    logic           req_valid8 = 1'b0;
    logic           req_ready8;
    logic           req_wb8 = 1'b0;
    logic [LW8-1:0] req_wb_line8 = '0;
    logic [LW8-1:0] req_fill_line8 = '0;
    logic [IW8-1:0] wb_rd_idx8;
    logic [DW-1:0]  wb_rd_data8;
    logic           fill_we8;
    logic [IW8-1:0] fill_idx8;
    logic [DW-1:0]  fill_data8;
    logic           done8;
    logic           mem_en8;
    logic [NC-1:0]  mem_we8;
    logic [AW-1:0]  mem_addr8;
    logic [DW-1:0]  mem_din8;
    logic [DW-1:0]  mem_dout8;
    logic [DW-1:0]  cache8 [0:W8-1];
    logic [DW-1:0]  bram8 [0:(1<<AW)-1];

    assign wb_rd_data8 = cache8[wb_rd_idx8];

    dcache_line_xfer_ctrl #(.ADDR_WIDTH(AW), .NUM_COL(NC), .COL_WIDTH(CW), .WORDS_PER_LINE(W8)) u_dut8 (
        .clk(clk), .nrst(nrst), .req_valid(req_valid8), .req_ready(req_ready8), .req_wb(req_wb8),
        .req_wb_line(req_wb_line8), .req_fill_line(req_fill_line8), .wb_rd_idx(wb_rd_idx8),
        .wb_rd_data(wb_rd_data8), .fill_we(fill_we8), .fill_idx(fill_idx8), .fill_data(fill_data8),
        .done(done8), .mem_en(mem_en8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_din(mem_din8),
        .mem_dout(mem_dout8));

    function automatic logic [DW-1:0] init4(input int a);
        return 32'hA000_0000 | 32'(a);
    endfunction

    function automatic logic [DW-1:0] init8(input int a);
        return 32'hB000_0000 | 32'(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // BRAM port-B models: registered read, byte-lane writes.
    initial begin
        for (int i = 0; i < (1<<AW); i++) bram[i] = init4(i);
        mem_dout = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                mem_dout <= bram[mem_addr];
                for (int b = 0; b < NC; b++)
                    if (mem_we[b]) bram[mem_addr][b*CW +: CW] <= mem_din[b*CW +: CW];
            end
        end
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) bram8[i] = init8(i);
        mem_dout8 = '0;
        forever begin
            @(posedge clk);
            if (mem_en8) begin
                mem_dout8 <= bram8[mem_addr8];
                for (int b = 0; b < NC; b++)
                    if (mem_we8[b]) bram8[mem_addr8][b*CW +: CW] <= mem_din8[b*CW +: CW];
            end
        end
    end

    // Transaction model: busy flag plus cycle number k since the accept edge.
    bit            m_busy = 1'b0;
    int            m_k = 0;
    bit            m_wb = 1'b0;
    logic [LW-1:0] m_wbl = '0;
    logic [LW-1:0] m_fl = '0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_busy = 1'b0;
            m_k    = 0;
        end else if (m_busy) begin
            if (m_k == (m_wb ? W : 0) + W + 2) m_busy = 1'b0;
            else m_k = m_k + 1;
        end else if (req_valid) begin
            m_busy = 1'b1;
            m_k    = 1;
            m_wb   = req_wb;
            m_wbl  = req_wb_line;
            m_fl   = req_fill_line;
        end
    end

    // Per-cycle comparison against the timeline implied by (busy, k).
    initial begin
        logic          e_ready, e_en, e_fwe, e_done;
        logic [NC-1:0] e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din, e_fdata;
        logic [IW-1:0] e_ridx, e_fidx;
        int            f;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init4(i);
        forever begin
            @(negedge clk);
            e_ready = 1'b1; e_en = 1'b0; e_we = '0; e_addr = '0; e_din = '0;
            e_ridx = '0; e_fwe = 1'b0; e_fidx = '0; e_fdata = '0; e_done = 1'b0;
            if (m_busy) begin
                f = m_wb ? W : 0;
                e_ready = 1'b0;
                if (m_wb && m_k <= W) begin
                    e_en   = 1'b1;
                    e_we   = '1;
                    e_ridx = IW'(m_k - 1);
                    e_addr = {m_wbl, e_ridx};
                    e_din  = cache[m_k - 1];
                    ref_mem[e_addr] = e_din;
                end
                if (m_k > f && m_k <= f + W) begin
                    e_en   = 1'b1;
                    e_addr = {m_fl, IW'(m_k - f - 1)};
                end
                if (m_k >= f + 2 && m_k <= f + W + 1) begin
                    e_fwe   = 1'b1;
                    e_fidx  = IW'(m_k - f - 2);
                    e_fdata = ref_mem[{m_fl, e_fidx}];
                end
                if (m_k == f + W + 2) e_done = 1'b1;
            end
            chk("req_ready", req_ready, e_ready);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_din", mem_din, e_din);
            chk("wb_rd_idx", wb_rd_idx, e_ridx);
            chk("fill_we", fill_we, e_fwe);
            chk("fill_idx", fill_idx, e_fidx);
            chk("fill_data", fill_data, e_fdata);
            chk("done", done, e_done);
        end
    end

    // Directed-run observations.
    int            d_done, d_ndone, d_nwr, d_nrd, d_rdy1;
    logic [DW-1:0] d_fd [0:W-1];

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(req_ready && !m_busy && nrst) && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle_timeout", t < 60, 1);
    endtask

    task automatic run_dir(input bit wb, input logic [LW-1:0] wbl, input logic [LW-1:0] fl,
                           input int rst_at, input bit hold);
        wait_idle();
        @(posedge clk); #1;
        req_valid = 1'b1; req_wb = wb; req_wb_line = wbl; req_fill_line = fl;
        @(negedge clk);
        chk("dir_ready_before_accept", req_ready, 1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        req_wb = ~wb;
        req_wb_line = LW'($urandom_range(0, 3));
        req_fill_line = LW'($urandom_range(0, 3));
        d_done = -1; d_ndone = 0; d_nwr = 0; d_nrd = 0; d_rdy1 = -1;
        for (int i = 0; i < W; i++) d_fd[i] = '0;
        for (int k = 1; k <= 16; k++) begin
            if (k == rst_at) begin
                nrst = 1'b0;
                #1;
                chk("rst_now_mem_en", mem_en, 0);
                chk("rst_now_mem_we", mem_we, 0);
                chk("rst_now_mem_addr", mem_addr, 0);
                chk("rst_now_ready", req_ready, 1);
            end
            @(negedge clk);
            if (done) begin
                d_ndone++;
                if (d_done < 0) d_done = k;
            end
            if (mem_en && mem_we == 4'hF) d_nwr++;
            if (mem_en && mem_we == 4'h0) d_nrd++;
            if (fill_we) d_fd[fill_idx] = fill_data;
            if (req_ready && d_rdy1 < 0) d_rdy1 = k;
            @(posedge clk); #1;
        end
        nrst = 1'b1;
        req_valid = 1'b0;
    endtask

    initial begin
        int            d8_done, d8_nwr, d8_nrd, mism;
        logic [W8-1:0] bm8;
        logic [DW-1:0] fd8 [0:W8-1];

        for (int i = 0; i < W; i++) cache[i] = '0;
        for (int i = 0; i < W8; i++) cache8[i] = '0;
        nrst = 1'b0;
        #2;
        chk("reset_ready", req_ready, 1);
        chk("reset_mem_en", mem_en, 0);
        chk("reset_fill_we", fill_we, 0);
        chk("reset_done8", done8, 0);
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;

        // Clean fill of line 0x010.
        run_dir(1'b0, 10'h005, 10'h010, 0, 1'b0);
        chk("s1_done_cycle", d_done, 6);
        chk("s1_writes", d_nwr, 0);
        chk("s1_reads", d_nrd, 4);
        for (int i = 0; i < W; i++) chk("s1_fill_data", d_fd[i], 32'hA000_0040 + 32'(i));

        // Dirty victim 0x005, fill 0x010.
        for (int i = 0; i < W; i++) cache[i] = 32'hD0D0_0000 + 32'(i);
        run_dir(1'b1, 10'h005, 10'h010, 0, 1'b0);
        chk("s2_done_cycle", d_done, 10);
        chk("s2_writes", d_nwr, 4);
        chk("s2_reads", d_nrd, 4);
        for (int i = 0; i < W; i++) chk("s2_bram_wb", bram[12'h014 + i], 32'hD0D0_0000 + 32'(i));
        for (int i = 0; i < W; i++) chk("s2_fill_data", d_fd[i], 32'hA000_0040 + 32'(i));

        // Same line written back then refilled.
        for (int i = 0; i < W; i++) cache[i] = 32'hE0E0_0000 + 32'(i);
        run_dir(1'b1, 10'h005, 10'h005, 0, 1'b0);
        chk("s3_done_cycle", d_done, 10);
        for (int i = 0; i < W; i++) chk("s3_fill_data", d_fd[i], 32'hE0E0_0000 + 32'(i));

        // req_valid held throughout.
        run_dir(1'b1, 10'h006, 10'h011, 0, 1'b1);
        chk("s4_done_cycle", d_done, 10);
        chk("s4_done_count", d_ndone, 1);
        chk("s4_first_ready", d_rdy1, 11);

        // Reset in cycle 3 of a dirty transaction.
        for (int i = 0; i < W; i++) cache[i] = 32'hF0F0_0000 + 32'(i);
        run_dir(1'b1, 10'h007, 10'h012, 3, 1'b0);
        chk("s5_no_done", d_ndone, 0);
        chk("s5_bram_1c", bram[12'h01C], 32'hF0F0_0000);
        chk("s5_bram_1d", bram[12'h01D], 32'hF0F0_0001);
        chk("s5_bram_1e", bram[12'h01E], 32'hA000_001E);
        chk("s5_bram_1f", bram[12'h01F], 32'hA000_001F);

        // Accepted again after release.
        run_dir(1'b0, 10'h000, 10'h012, 0, 1'b0);
        chk("s6_done_cycle", d_done, 6);
        for (int i = 0; i < W; i++) chk("s6_fill_data", d_fd[i], 32'hA000_0048 + 32'(i));

        // 8-word lines: dirty, wb line 2 (0x010..0x017), fill line 3 (0x018..0x01F).
        @(posedge clk); #1;
        for (int i = 0; i < W8; i++) cache8[i] = 32'hC8C8_0000 + 32'(i);
        req_valid8 = 1'b1; req_wb8 = 1'b1; req_wb_line8 = 9'd2; req_fill_line8 = 9'd3;
        @(negedge clk);
        chk("w8_ready", req_ready8, 1);
        @(posedge clk); #1;
        req_valid8 = 1'b0;
        d8_done = -1; d8_nwr = 0; d8_nrd = 0; bm8 = '0;
        for (int i = 0; i < W8; i++) fd8[i] = '0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (done8 && d8_done < 0) d8_done = k;
            if (mem_en8 && mem_we8 == 4'hF) begin
                chk("w8_wr_addr", mem_addr8, 12'h010 + 12'(d8_nwr));
                d8_nwr++;
            end
            if (mem_en8 && mem_we8 == 4'h0) begin
                chk("w8_rd_addr", mem_addr8, 12'h018 + 12'(d8_nrd));
                d8_nrd++;
            end
            if (fill_we8) begin
                bm8[fill_idx8] = 1'b1;
                fd8[fill_idx8] = fill_data8;
            end
            @(posedge clk); #1;
        end
        chk("w8_done_cycle", d8_done, 18);
        chk("w8_writes", d8_nwr, 8);
        chk("w8_reads", d8_nrd, 8);
        chk("w8_fill_idx_cover", bm8, 8'hFF);
        for (int i = 0; i < W8; i++) chk("w8_fill_data", fd8[i], 32'hB000_0018 + 32'(i));
        for (int i = 0; i < W8; i++) chk("w8_bram_wb", bram8[12'h010 + i], 32'hC8C8_0000 + 32'(i));

        // Random traffic; the per-cycle model does the checking.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!nrst) nrst = 1'b1;
            else if (m_busy && $urandom_range(0, 40) == 0) nrst = 1'b0;
            req_valid = ($urandom_range(0, 3) != 0);
            req_wb = 1'($urandom_range(0, 1));
            req_wb_line = LW'($urandom_range(0, 7));
            req_fill_line = ($urandom_range(0, 1) == 1) ? req_wb_line : LW'($urandom_range(0, 7));
            for (int i = 0; i < W; i++) cache[i] = $urandom;
        end
        @(posedge clk); #1;
        nrst = 1'b1;
        req_valid = 1'b0;
        wait_idle();
        @(posedge clk); #1;
        mism = 0;
        for (int i = 0; i < (1<<AW); i++) if (bram[i] !== ref_mem[i]) mism++;
        chk("final_bram_contents", mism, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
